// File: rtl/clock_cfg_sequencer.sv
// clock_cfg_sequencer
// Sits between the core's clock config register and the clock generator.
// A CLKSEL change is only applied once any newly enabled oscillator/PLL has
// settled (and, for the PLL, locked). The software RESET bit becomes a timed
// reset pulse back into the core. The cog clock never switches onto an
// unsettled source.
module clock_cfg_sequencer #(
  parameter int SETTLE_CYCLES = 16000, // min wait after enabling OSCENA/PLLENA
  parameter int LOCK_TIMEOUT  = 64000, // max wait for i_pll_locked before abort
  parameter int SWITCH_GAP    = 8,     // busy hold after a CLKSEL write
  parameter int RES_CYCLES    = 1024   // o_soft_res pulse length
) (
  input  logic       i_clock,      // 160MHz fixed clock
  input  logic       i_resn,       // async active-low reset
  input  logic [7:0] i_cfg_in,     // [7]RESET [6]PLLENA [5]OSCENA [4:3]OSCM [2:0]CLKSEL
  input  logic       i_pll_locked, // PLL lock status, synchronous to i_clock
  output logic [6:0] o_cfg_out,    // applied config to the clock generator
  output logic       o_soft_res,   // reset request into the core
  output logic       o_busy,       // high whenever not IDLE
  output logic       o_lock_err    // sticky lock-timeout flag
);

  // Counter is shared by all timed states; sized for the longest interval.
  localparam int MAX_AB  = (SETTLE_CYCLES > LOCK_TIMEOUT) ? SETTLE_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_ABC = (MAX_AB > RES_CYCLES) ? MAX_AB : RES_CYCLES;
  localparam int CNT_MAX = (MAX_ABC > SWITCH_GAP) ? MAX_ABC : SWITCH_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);

  // Terminal counts: each timed state ends on the cycle whose count equals N-1,
  // so the state lasts exactly N cycles.
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(SWITCH_GAP - 1);
  localparam logic [CW-1:0] RES_LAST    = CW'(RES_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT     = '1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SETTLE   = 2'd1,
    S_SWITCH   = 2'd2,
    S_SOFT_RES = 2'd3
  } state_t;

  state_t        r_state;
  logic [7:0]    r_cfg_q;        // single registered copy of i_cfg_in
  logic [6:0]    r_cfg_out;
  logic [6:0]    r_target;       // config being moved towards
  logic [CW-1:0] r_cnt;
  logic          r_soft_res;
  logic          r_lock_err;
  logic [6:0]    r_fail_target;  // target that last timed out on lock
  logic          r_fail_valid;   // suppresses retrying r_fail_target

  state_t        w_state_next;
  logic [6:0]    w_cfg_out_next;
  logic [6:0]    w_target_next;
  logic [CW-1:0] w_cnt_next;
  logic          w_soft_res_next;
  logic          w_lock_err_next;
  logic [6:0]    w_fail_target_next;
  logic          w_fail_valid_next;

  logic [CW-1:0] w_cnt_inc;
  logic          w_need_settle;
  logic          w_blocked;
  logic          w_change;

  // Saturating increment: the counter never wraps.
  assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;

  // A settle phase is only needed for enables going 0->1; disables switch directly.
  assign w_need_settle = (r_cfg_q[6] & ~r_cfg_out[6]) | (r_cfg_q[5] & ~r_cfg_out[5]);

  // A target that already timed out is not retried until the core writes something else.
  assign w_blocked = r_fail_valid && (r_cfg_q[6:0] == r_fail_target);

  assign w_change  = (r_cfg_q[6:0] != r_cfg_out) && !w_blocked;

  // State and datapath registers; reset forces the safe RCFAST configuration.
  always_ff @(posedge i_clock or negedge i_resn) begin
    if (!i_resn) begin
      r_state       <= S_IDLE;
      r_cfg_q       <= 8'h00;
      r_cfg_out     <= 7'h00;
      r_target      <= 7'h00;
      r_cnt         <= '0;
      r_soft_res    <= 1'b0;
      r_lock_err    <= 1'b0;
      r_fail_target <= 7'h00;
      r_fail_valid  <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cfg_q       <= i_cfg_in;
      r_cfg_out     <= w_cfg_out_next;
      r_target      <= w_target_next;
      r_cnt         <= w_cnt_next;
      r_soft_res    <= w_soft_res_next;
      r_lock_err    <= w_lock_err_next;
      r_fail_target <= w_fail_target_next;
      r_fail_valid  <= w_fail_valid_next;
    end
  end

  // Next-state and next-output decisions, all based on the registered config.
  always_comb begin
    w_state_next       = r_state;
    w_cfg_out_next     = r_cfg_out;
    w_target_next      = r_target;
    w_cnt_next         = r_cnt;
    w_soft_res_next    = r_soft_res;
    w_lock_err_next    = r_lock_err;
    w_fail_target_next = r_fail_target;
    w_fail_valid_next  = r_fail_valid;

    case (r_state)
      S_IDLE: begin
        if (r_cfg_q[7]) begin
          // Soft reset wins over any simultaneous config change.
          w_state_next    = S_SOFT_RES;
          w_cfg_out_next  = 7'h00;
          w_soft_res_next = 1'b1;
          w_cnt_next      = '0;
        end else begin
          if (r_fail_valid && !w_blocked) begin
            w_fail_valid_next = 1'b0;
          end
          if (w_change) begin
            w_target_next = r_cfg_q[6:0];
            w_cnt_next    = '0;
            if (w_need_settle) begin
              // Turn the new source on but keep running from the old CLKSEL.
              w_cfg_out_next = {r_cfg_q[6:3], r_cfg_out[2:0]};
              w_state_next   = S_SETTLE;
            end else begin
              // Whole target written at once, so CLKSEL never lags a disable.
              w_cfg_out_next = r_cfg_q[6:0];
              w_state_next   = S_SWITCH;
            end
          end
        end
      end

      S_SETTLE: begin
        w_cnt_next = w_cnt_inc;
        if ((r_cnt >= SETTLE_LAST) && (i_pll_locked || !r_target[6])) begin
          w_cfg_out_next = r_target;
          w_cnt_next     = '0;
          w_state_next   = S_SWITCH;
        end else if (r_target[6] && (r_cnt >= LOCK_LAST)) begin
          // Give up: enables stay applied, CLKSEL stays on the old source.
          w_lock_err_next    = 1'b1;
          w_fail_target_next = r_target;
          w_fail_valid_next  = 1'b1;
          w_state_next       = S_IDLE;
        end
      end

      S_SWITCH: begin
        if (r_cnt >= GAP_LAST) begin
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end

      S_SOFT_RES: begin
        if (r_cnt >= RES_LAST) begin
          w_soft_res_next = 1'b0;
          w_state_next    = S_IDLE;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign o_cfg_out  = r_cfg_out;
  assign o_soft_res = r_soft_res;
  assign o_busy     = (r_state != S_IDLE);
  assign o_lock_err = r_lock_err;

endmodule

// File: tb/tb_clock_cfg_sequencer.sv
// Self-checking bench for clock_cfg_sequencer: a directed vector table for
// the main sequences plus hand-written soft-reset and async-reset sequences.
module tb_clock_cfg_sequencer;

  localparam int SETTLE = 200;
  localparam int LOCKTO = 500;
  localparam int GAP    = 8;
  localparam int RES    = 1024;

  logic       clk;
  logic       resn;
  logic [7:0] cfg_in;
  logic       pll_locked;
  logic [6:0] cfg_out;
  logic       soft_res;
  logic       busy;
  logic       lock_err;

  int n_checks = 0;
  int n_errors = 0;

  clock_cfg_sequencer #(
    .SETTLE_CYCLES (SETTLE),
    .LOCK_TIMEOUT  (LOCKTO),
    .SWITCH_GAP    (GAP),
    .RES_CYCLES    (RES)
  ) dut (
    .i_clock      (clk),
    .i_resn       (resn),
    .i_cfg_in     (cfg_in),
    .i_pll_locked (pll_locked),
    .o_cfg_out    (cfg_out),
    .o_soft_res   (soft_res),
    .o_busy       (busy),
    .o_lock_err   (lock_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cfg;
    logic       lock;
    int         steps;   // negedges to advance before sampling
    logic [6:0] out;
    logic       bsy;
    logic       sr;
    logic       le;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [7:0] cfg, input logic lock, input int steps,
                              input logic [6:0] out, input logic bsy, input logic sr,
                              input logic le);
    vec_t v;
    v.cfg = cfg; v.lock = lock; v.steps = steps;
    v.out = out; v.bsy = bsy; v.sr = sr; v.le = le;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic [6:0] out, input logic bsy,
                           input logic sr, input logic le);
    check({tag, " cfg_out"},  int'(cfg_out),  int'(out));
    check({tag, " busy"},     int'(busy),     int'(bsy));
    check({tag, " soft_res"}, int'(soft_res), int'(sr));
    check({tag, " lock_err"}, int'(lock_err), int'(le));
  endtask

  initial begin
    int cnt;
    int guard;
    logic out_seen_nonzero;

    resn       = 1'b0;
    cfg_in     = 8'h00;
    pll_locked = 1'b0;

    // Test 1: reset values, then idle with cfg_in=0.
    step(3);
    check_all("in_reset", 7'h00, 1'b0, 1'b0, 1'b0);
    resn = 1'b1;

    vecs.push_back(mk(8'h00, 1'b0, 5,          7'h00, 1'b0, 1'b0, 1'b0)); // stays idle
    // Test 2: enable PLL+OSC, CLKSEL=3; lock arrives late.
    vecs.push_back(mk(8'h6B, 1'b0, 1,          7'h00, 1'b0, 1'b0, 1'b0)); // cfg_q latency
    vecs.push_back(mk(8'h6B, 1'b0, 1,          7'h68, 1'b1, 1'b0, 1'b0)); // enables applied
    vecs.push_back(mk(8'h6B, 1'b0, SETTLE - 1, 7'h68, 1'b1, 1'b0, 1'b0)); // still settling
    vecs.push_back(mk(8'h6B, 1'b0, 11,         7'h68, 1'b1, 1'b0, 1'b0)); // settled, no lock
    vecs.push_back(mk(8'h6B, 1'b1, 1,          7'h6B, 1'b1, 1'b0, 1'b0)); // lock -> switch
    vecs.push_back(mk(8'h6B, 1'b1, GAP - 1,    7'h6B, 1'b1, 1'b0, 1'b0)); // gap hold
    vecs.push_back(mk(8'h6B, 1'b1, 1,          7'h6B, 1'b0, 1'b0, 1'b0)); // back to idle
    // Test 4: disable everything, no settle phase.
    vecs.push_back(mk(8'h00, 1'b1, 1,          7'h6B, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(8'h00, 1'b1, 1,          7'h00, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(8'h00, 1'b1, GAP - 1,    7'h00, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(8'h00, 1'b1, 1,          7'h00, 1'b0, 1'b0, 1'b0));
    // Test 3: PLL never locks -> timeout, old CLKSEL kept, no retry.
    vecs.push_back(mk(8'h6B, 1'b0, 2,          7'h68, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(8'h6B, 1'b0, LOCKTO - 1, 7'h68, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(8'h6B, 1'b0, 1,          7'h68, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(8'h6B, 1'b0, 20,         7'h68, 1'b0, 1'b0, 1'b1)); // not retried
    vecs.push_back(mk(8'h00, 1'b0, 2,          7'h00, 1'b1, 1'b0, 1'b1)); // new cfg accepted
    vecs.push_back(mk(8'h00, 1'b0, GAP,        7'h00, 1'b0, 1'b0, 1'b1));

    for (int i = 0; i < vecs.size(); i++) begin
      cfg_in     = vecs[i].cfg;
      pll_locked = vecs[i].lock;
      step(vecs[i].steps);
      $display("row %0d: cfg_in=%02h lock=%0b -> cfg_out=%02h busy=%0b soft_res=%0b lock_err=%0b",
               i, cfg_in, pll_locked, cfg_out, busy, soft_res, lock_err);
      check_all($sformatf("row%0d", i), vecs[i].out, vecs[i].bsy, vecs[i].sr, vecs[i].le);
    end

    // Test 5: RESET together with a CLKSEL change; RESET held -> second pulse.
    cfg_in = 8'h83;
    out_seen_nonzero = 1'b0;
    step(1);
    check("sr_latency", int'(soft_res), 0);
    step(1);
    check("sr_start", int'(soft_res), 1);
    check("sr_start_busy", int'(busy), 1);
    cnt = 0; guard = 0;
    while (soft_res === 1'b1 && guard < 3 * RES) begin
      if (cfg_out !== 7'h00) out_seen_nonzero = 1'b1;
      cnt++; guard++;
      step(1);
    end
    $display("soft reset pulse 1: %0d cycles", cnt);
    check("sr_pulse1_len", cnt, RES);
    check("sr_gap_busy", int'(busy), 0);
    step(1);
    check("sr_repulse", int'(soft_res), 1);
    cfg_in = 8'h00;
    cnt = 0; guard = 0;
    while (soft_res === 1'b1 && guard < 3 * RES) begin
      if (cfg_out !== 7'h00) out_seen_nonzero = 1'b1;
      cnt++; guard++;
      step(1);
    end
    $display("soft reset pulse 2: %0d cycles", cnt);
    check("sr_pulse2_len", cnt, RES);
    check("sr_clksel_never_applied", int'(out_seen_nonzero), 0);
    step(10);
    check_all("after_sr", 7'h00, 1'b0, 1'b0, 1'b1);

    // Test 6: async reset in the middle of SETTLE, then restart.
    cfg_in     = 8'h6B;
    pll_locked = 1'b0;
    step(2);
    check_all("pre_rst_settle", 7'h68, 1'b1, 1'b0, 1'b1);
    step(10);
    resn = 1'b0;
    #1;
    $display("async reset mid-settle: cfg_out=%02h busy=%0b lock_err=%0b", cfg_out, busy, lock_err);
    check_all("async_rst", 7'h00, 1'b0, 1'b0, 1'b0);
    step(2);
    resn = 1'b1;
    step(1);
    check_all("restart_idle", 7'h00, 1'b0, 1'b0, 1'b0);
    step(1);
    check_all("restart_settle", 7'h68, 1'b1, 1'b0, 1'b0);
    pll_locked = 1'b1;
    step(SETTLE - 1);
    check("restart_settle_hold", int'(cfg_out), 32'h68);
    step(1);
    check_all("restart_switch", 7'h6B, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
